cd_request_scheduler: RTL and testbench

//  Front-end stage directly upstream of the dictionary compression/decompression engine.
//  - Buffers tagged requests in a FIFO and issues one engine command at a time.
//  - Captures the engine's registered response and returns it as a tagged result.
//  - Result is returned over a valid/ready output with full backpressure.

---
 rtl/cd_request_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_cd_request_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_request_scheduler.sv
// Request scheduler in front of the dictionary compression engine: buffers tagged
// requests, issues one engine command at a time and returns tagged results over valid/ready.
module cd_request_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 80,
    parameter int IDX_W      = 8,
    parameter int TAG_W      = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [1:0]        eng_command,
    output logic [DATA_W-1:0] eng_data_in,
    output logic [IDX_W-1:0]  eng_compressed_in,
    input  logic [IDX_W-1:0]  eng_compressed_out,
    input  logic [DATA_W-1:0] eng_decompressed_out,
    input  logic [1:0]        eng_response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [1:0]        cmd;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t              fifo_mem_q [FIFO_DEPTH];
    req_t              fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    state_t            state_q, state_d;
    logic [1:0]        eng_command_q, eng_command_d;
    logic [DATA_W-1:0] eng_data_in_q, eng_data_in_d;
    logic [IDX_W-1:0]  eng_cidx_q, eng_cidx_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              push, pop, issue;
    req_t              head;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign req_ready = (fifo_count_q < CNT_W'(FIFO_DEPTH));
    assign head      = fifo_mem_q[rd_ptr_q];

    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q;
        state_d       = state_q;
        eng_command_d = eng_command_q;
        eng_data_in_d = eng_data_in_q;
        eng_cidx_d    = eng_cidx_q;
        tag_d         = tag_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_idx_d     = rsp_idx_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        err_count_d   = err_count_q;
        push          = req_valid && req_ready;
        pop           = 1'b0;
        issue         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_count_q != '0) issue = 1'b1;
            end
            S_ISSUE: begin
                state_d       = S_WAIT;
                eng_command_d = 2'b00;
            end
            S_WAIT: begin
                state_d      = S_HOLD;
                rsp_valid_d  = 1'b1;
                rsp_status_d = eng_response;
                rsp_idx_d    = (eng_response == 2'b01) ? eng_compressed_out : '0;
                rsp_data_d   = (eng_response == 2'b10) ? eng_decompressed_out : '0;
                rsp_tag_d    = tag_q;
                if (eng_response == 2'b11 && err_count_q != 8'hFF)
                    err_count_d = err_count_q + 8'd1;
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (fifo_count_q != '0) issue = 1'b1;
                    else state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The engine inputs are loaded on the edge that enters ISSUE, so they are live for that whole cycle.
        if (issue) begin
            state_d       = S_ISSUE;
            pop           = 1'b1;
            eng_command_d = head.cmd;
            eng_data_in_d = head.data;
            eng_cidx_d    = head.idx;
            tag_d         = head.tag;
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{cmd: req_cmd, data: req_data, idx: req_idx, tag: req_tag};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            state_q       <= S_IDLE;
            eng_command_q <= 2'b00;
            eng_data_in_q <= '0;
            eng_cidx_q    <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= 2'b00;
            rsp_idx_q     <= '0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            err_count_q   <= 8'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            state_q       <= state_d;
            eng_command_q <= eng_command_d;
            eng_data_in_q <= eng_data_in_d;
            eng_cidx_q    <= eng_cidx_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_idx_q     <= rsp_idx_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            err_count_q   <= err_count_d;
        end
    end

    assign eng_command       = eng_command_q;
    assign eng_data_in       = eng_data_in_q;
    assign eng_compressed_in = eng_cidx_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_status        = rsp_status_q;
    assign rsp_idx           = rsp_idx_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_tag           = rsp_tag_q;
    assign fifo_count        = fifo_count_q;
    assign err_count         = err_count_q;

endmodule

// File: tb/tb_cd_request_scheduler.sv
// Scoreboard bench for cd_request_scheduler with a behavioural dictionary engine
// and a queue-based reference model of the expected tagged results.
module tb_cd_request_scheduler;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 80;
    localparam int IDX_W      = 8;
    localparam int TAG_W      = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_cmd = 2'b00;
    logic [DATA_W-1:0] req_data = '0;
    logic [IDX_W-1:0]  req_idx = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [1:0]        eng_command;
    logic [DATA_W-1:0] eng_data_in;
    logic [IDX_W-1:0]  eng_compressed_in;
    logic [IDX_W-1:0]  eng_compressed_out;
    logic [DATA_W-1:0] eng_decompressed_out;
    logic [1:0]        eng_response;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [IDX_W-1:0]  rsp_idx;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic [2:0]        fifo_count;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    cd_request_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_data(req_data), .req_idx(req_idx), .req_tag(req_tag),
        .eng_command(eng_command), .eng_data_in(eng_data_in),
        .eng_compressed_in(eng_compressed_in), .eng_compressed_out(eng_compressed_out),
        .eng_decompressed_out(eng_decompressed_out), .eng_response(eng_response),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_idx(rsp_idx), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .fifo_count(fifo_count), .err_count(err_count)
    );

    typedef struct {
        logic [1:0]  st;
        logic [7:0]  idx;
        logic [79:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [79:0] ref_dict [256];
    int          ref_n = 0;
    logic [79:0] eng_dict [256];
    int          eng_n = 0;
    logic        rr_rand = 1'b0;
    logic        rr_force = 1'b0;
    logic        rnd_rdy = 1'b0;

    assign rsp_ready = rr_rand ? rnd_rdy : rr_force;

    function automatic logic [79:0] rnd80();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    // Engine: registered outputs, fields not selected by the status are filled with junk.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_n = 0;
            eng_response         <= 2'b00;
            eng_compressed_out   <= '0;
            eng_decompressed_out <= '0;
        end else begin
            eng_compressed_out   <= 8'($urandom());
            eng_decompressed_out <= rnd80();
            case (eng_command)
                2'b00: eng_response <= 2'b00;
                2'b01: begin
                    if (eng_n < 256) begin
                        eng_dict[8'(eng_n)] = eng_data_in;
                        eng_compressed_out <= 8'(eng_n);
                        eng_n = eng_n + 1;
                        eng_response <= 2'b01;
                    end else eng_response <= 2'b11;
                end
                2'b10: begin
                    if (int'(eng_compressed_in) < eng_n) begin
                        eng_decompressed_out <= eng_dict[eng_compressed_in];
                        eng_response <= 2'b10;
                    end else eng_response <= 2'b11;
                end
                default: eng_response <= 2'b11;
            endcase
        end
    end

    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    // Reference model: what the result of each accepted request must be, in acceptance order.
    task automatic ref_push(input logic [1:0] c, input logic [79:0] d, input logic [7:0] i,
                            input logic [3:0] t);
        exp_t e;
        e.st = 2'b11; e.idx = 8'd0; e.data = 80'd0; e.tag = t;
        if (c == 2'b00) e.st = 2'b00;
        else if (c == 2'b01 && ref_n < 256) begin
            e.st = 2'b01; e.idx = 8'(ref_n);
            ref_dict[8'(ref_n)] = d; ref_n = ref_n + 1;
        end else if (c == 2'b10 && int'(i) < ref_n) begin
            e.st = 2'b10; e.data = ref_dict[i];
        end
        sb_q.push_back(e);
    endtask

    int   mon_err = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) mon_err = 0;
        else if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp: got tag=%0d status=%0d, required no result", rsp_tag, rsp_status);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.st == 2'b11 && mon_err < 255) mon_err = mon_err + 1;
                if (rsp_status !== mon_e.st || rsp_idx !== mon_e.idx || rsp_data !== mon_e.data ||
                    rsp_tag !== mon_e.tag || err_count !== 8'(mon_err)) begin
                    n_bad++;
                    $display("FAIL rsp: got st=%0d idx=%0d data=%h tag=%0d err=%0d, required st=%0d idx=%0d data=%h tag=%0d err=%0d",
                             rsp_status, rsp_idx, rsp_data, rsp_tag, err_count,
                             mon_e.st, mon_e.idx, mon_e.data, mon_e.tag, mon_err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; rr_force = 1'b0; rr_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        ref_n = 0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [79:0] d, input logic [7:0] i,
                        input logic [3:0] t);
        int k;
        req_valid = 1'b1; req_cmd = c; req_data = d; req_idx = i; req_tag = t;
        k = 0;
        while (!req_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got req_ready=0 for 200 cycles, required 1");
        end else begin
            @(posedge clk); #1;
            ref_push(c, d, i, t);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        check("drain_pending", 96'(sb_q.size()), 96'(0));
    endtask

    logic [94:0] snap;
    logic        stable;
    logic [79:0] a_w, b_w;

    initial begin
        do_reset();
        check("rst_rsp_valid", 96'(rsp_valid), 96'(0));
        check("rst_req_ready", 96'(req_ready), 96'(1));
        check("rst_fifo_count", 96'(fifo_count), 96'(0));
        check("rst_err_count", 96'(err_count), 96'(0));
        check("rst_eng_command", 96'(eng_command), 96'(0));

        // Single compress: ISSUE cycle, WAIT cycle, result three cycles after the push.
        rr_force = 1'b1;
        req_valid = 1'b1; req_cmd = 2'b01; req_data = 80'h1234; req_idx = 8'd0; req_tag = 4'd5;
        @(posedge clk); #1;
        ref_push(2'b01, 80'h1234, 8'd0, 4'd5);
        req_valid = 1'b0;
        check("t1_count_after_push", 96'(fifo_count), 96'(1));
        @(posedge clk); #1;
        check("t1_issue_cmd", 96'(eng_command), 96'(1));
        check("t1_issue_data", 96'(eng_data_in), 96'(80'h1234));
        @(posedge clk); #1;
        check("t1_wait_cmd", 96'(eng_command), 96'(0));
        check("t1_wait_data_hold", 96'(eng_data_in), 96'(80'h1234));
        check("t1_wait_no_valid", 96'(rsp_valid), 96'(0));
        @(posedge clk); #1;
        check("t1_rsp_valid", 96'(rsp_valid), 96'(1));
        check("t1_rsp_status", 96'(rsp_status), 96'(1));
        check("t1_rsp_idx", 96'(rsp_idx), 96'(0));
        check("t1_rsp_tag", 96'(rsp_tag), 96'(5));
        wait_drain();

        // Compress A, compress B, decompress index 1.
        do_reset();
        rr_force = 1'b1;
        a_w = rnd80(); b_w = rnd80();
        send(2'b01, a_w, 8'd0, 4'd1);
        send(2'b01, b_w, 8'd0, 4'd2);
        send(2'b10, 80'd0, 8'd1, 4'd3);
        wait_drain();

        // Backpressure: five requests with rsp_ready low.
        rr_force = 1'b0;
        for (int n = 0; n < 5; n++)
            send(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, rnd80(), 8'($urandom_range(0, 4)), 4'(6 + n));
        check("bp_req_ready_low", 96'(req_ready), 96'(0));
        check("bp_fifo_full", 96'(fifo_count), 96'(4));
        snap = {rsp_valid, rsp_status, rsp_idx, rsp_data, rsp_tag};
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if ({rsp_valid, rsp_status, rsp_idx, rsp_data, rsp_tag} !== snap) stable = 1'b0;
        end
        check("bp_hold_valid", 96'(rsp_valid), 96'(1));
        check("bp_hold_stable", 96'(stable), 96'(1));
        // Push offered while full in the same cycle the head is popped: refused, count drops by one.
        req_valid = 1'b1; req_cmd = 2'b01; req_data = rnd80(); req_tag = 4'd11;
        rr_force = 1'b1;
        @(posedge clk); #1;
        rr_force = 1'b0; req_valid = 1'b0;
        check("full_pop_count", 96'(fifo_count), 96'(3));
        check("full_pop_ready", 96'(req_ready), 96'(1));
        rr_force = 1'b1;
        wait_drain();

        // Invalid commands and err_count saturation.
        do_reset();
        rr_force = 1'b1;
        for (int n = 0; n < 3; n++) send(2'b11, rnd80(), 8'($urandom()), 4'(n));
        wait_drain();
        check("err_three", 96'(err_count), 96'(3));
        for (int n = 0; n < 300; n++) send(2'b11, rnd80(), 8'($urandom()), 4'(n));
        wait_drain();
        check("err_saturate", 96'(err_count), 96'(255));

        // Reset asserted while the request is in WAIT.
        req_valid = 1'b1; req_cmd = 2'b01; req_data = rnd80(); req_tag = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        check("rstwait_rsp_valid", 96'(rsp_valid), 96'(0));
        check("rstwait_fifo_count", 96'(fifo_count), 96'(0));
        check("rstwait_err_count", 96'(err_count), 96'(0));
        @(posedge clk); #1;
        sb_q.delete();
        ref_n = 0;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rstwait_no_result", 96'(rsp_valid), 96'(0));
        send(2'b01, 80'hBEEF, 8'd0, 4'd4);
        wait_drain();

        // Randomized traffic with random backpressure.
        rr_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int r;
            int gap;
            logic [1:0] c;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            r = $urandom_range(0, 7);
            c = (r < 4) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b00 : 2'b11;
            send(c, rnd80(), 8'($urandom_range(0, (ref_n + 1 > 255) ? 255 : ref_n + 1)), 4'($urandom()));
        end
        wait_drain();
        rr_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion within time limit, required completion");
        $fatal(1);
    end

endmodule
